clint: RTL and testbench

Core-local interruptor: the memory-mapped responder that answers core load/store requests decoded into the `clint_base_addr`–`clint_top_addr` window. It owns `msip`, `mtimecmp` and `mtime`. `mtime` advances at the real-time-clock rate, derived from the core clock by the `clk_divider_rtc` constant. It drives the machine software- and timer-interrupt lines into the CSR unit.

---
 rtl/clint_pkg.sv | 56 +++++
 rtl/clint_rtc_tick.sv | 36 +++
 rtl/clint.sv | 121 ++++++++++++
 tb/tb_clint.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// clint_pkg: constants and helpers shared by the core-local interruptor.
//   - clint address window, RTC divider constant
//   - register offsets inside the window
//   - register selector enum, word decode and byte-merge helpers
package clint_pkg;

    localparam int unsigned clk_freq = 50_000_000;
    localparam int unsigned rtc_freq = 6_250_000;

    localparam logic [31:0] clint_base_addr = 32'h0200_0000;
    localparam logic [31:0] clint_top_addr  = 32'h0200_FFFF;

    // Half-period of the RTC in core clocks, minus 1.
    localparam logic [15:0] clk_divider_rtc = 16'((clk_freq / rtc_freq) / 2 - 1);

    localparam logic [15:0] clint_msip_off     = 16'h0000;
    localparam logic [15:0] clint_mtimecmp_off = 16'h4000;
    localparam logic [15:0] clint_mtime_off    = 16'hBFF8;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_TIME_LO,
        REG_TIME_HI
    } clint_reg_e;

    // word = offset[15:2]
    function automatic clint_reg_e clint_decode(input logic [13:0] word);
        clint_reg_e r_sel;
        r_sel = REG_NONE;
        if (word == clint_msip_off[15:2])
            r_sel = REG_MSIP;
        else if (word == clint_mtimecmp_off[15:2])
            r_sel = REG_CMP_LO;
        else if (word == clint_mtimecmp_off[15:2] + 14'd1)
            r_sel = REG_CMP_HI;
        else if (word == clint_mtime_off[15:2])
            r_sel = REG_TIME_LO;
        else if (word == clint_mtime_off[15:2] + 14'd1)
            r_sel = REG_TIME_HI;
        return r_sel;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r_out;
        r_out = old_v;
        for (int i = 0; i < 4; i++)
            if (strb[i]) r_out[8*i +: 8] = new_v[8*i +: 8];
        return r_out;
    endfunction

endpackage

// File: rtl/clint_rtc_tick.sv
// clint_rtc_tick: derives the real-time-clock tick from the core clock.
//   clock  in   core clock
//   reset  in   asynchronous, active-high reset
//   tick   out  one-cycle strobe, once per RTC period
module clint_rtc_tick #(
    parameter logic [15:0] clk_divider_rtc = clint_pkg::clk_divider_rtc
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    logic [15:0] r_div;
    logic        r_rtc;
    logic        w_wrap;

    assign w_wrap = (r_div == clk_divider_rtc);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_div <= 16'd0;
            r_rtc <= 1'b0;
        end else if (w_wrap) begin
            r_div <= 16'd0;
            r_rtc <= ~r_rtc;
        end else begin
            r_div <= r_div + 16'd1;
        end
    end

    // rtc comes out of reset low, so the wrap taken while it is high closes a
    // full RTC period and opens the next rising phase. Ticking there puts the
    // first tick 2*(clk_divider_rtc+1) clocks after reset release.
    assign tick = w_wrap & r_rtc;

endmodule

// File: rtl/clint.sv
// clint: core-local interruptor (msip, mtimecmp, mtime).
//   clock, reset          core clock, asynchronous active-high reset
//   clint_valid/instr     request strobe, instruction-fetch flag
//   clint_addr/wdata/wstrb absolute byte address, write data, byte enables
//   clint_rdata/ready     registered response, one cycle after the request
//   clint_msip/mtip       machine software / timer interrupt pending
//   clint_mtime           current mtime for the time/timeh CSRs
module clint #(
    parameter logic [15:0] clk_divider_rtc = clint_pkg::clk_divider_rtc
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clint_valid,
    input  logic        clint_instr,
    input  logic [31:0] clint_addr,
    input  logic [31:0] clint_wdata,
    input  logic [3:0]  clint_wstrb,
    output logic [31:0] clint_rdata,
    output logic        clint_ready,
    output logic        clint_msip,
    output logic        clint_mtip,
    output logic [63:0] clint_mtime
);
    import clint_pkg::*;

    localparam logic [31:0] win_span = clint_top_addr - clint_base_addr;

    logic        w_tick;
    logic [31:0] w_off;
    logic        w_in_win;
    clint_reg_e  w_reg;
    logic        w_req;
    logic        w_wr;
    logic        w_rd;
    logic [63:0] w_mtime_inc;
    logic [63:0] w_mtime_next;
    logic [63:0] w_cmp_next;
    logic        w_msip_next;
    logic [31:0] w_rdata_next;

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_msip;
    logic        r_mtip;
    logic        r_ready;
    logic [31:0] r_rdata;

    clint_rtc_tick #(.clk_divider_rtc(clk_divider_rtc)) u_rtc_tick (
        .clock (clock),
        .reset (reset),
        .tick  (w_tick)
    );

    assign w_off    = clint_addr - clint_base_addr;
    assign w_in_win = (w_off <= win_span);
    assign w_reg    = w_in_win ? clint_decode(w_off[15:2]) : REG_NONE;

    // Fetches are answered with zero and never touch state.
    assign w_req = clint_valid & ~clint_instr;
    assign w_wr  = w_req & (|clint_wstrb);
    assign w_rd  = w_req & ~(|clint_wstrb);

    assign w_mtime_inc = r_mtime + 64'(w_tick);

    // A software write to an mtime word merges over the already-incremented
    // value, so unwritten bytes still advance on a coinciding tick.
    always_comb begin
        w_mtime_next = w_mtime_inc;
        w_cmp_next   = r_mtimecmp;
        w_msip_next  = r_msip;
        if (w_wr) begin
            case (w_reg)
                REG_MSIP:    if (clint_wstrb[0]) w_msip_next = clint_wdata[0];
                REG_CMP_LO:  w_cmp_next[31:0]    = byte_merge(r_mtimecmp[31:0], clint_wdata, clint_wstrb);
                REG_CMP_HI:  w_cmp_next[63:32]   = byte_merge(r_mtimecmp[63:32], clint_wdata, clint_wstrb);
                REG_TIME_LO: w_mtime_next[31:0]  = byte_merge(w_mtime_inc[31:0], clint_wdata, clint_wstrb);
                REG_TIME_HI: w_mtime_next[63:32] = byte_merge(w_mtime_inc[63:32], clint_wdata, clint_wstrb);
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rdata_next = 32'd0;
        if (w_rd) begin
            case (w_reg)
                REG_MSIP:    w_rdata_next = {31'd0, r_msip};
                REG_CMP_LO:  w_rdata_next = r_mtimecmp[31:0];
                REG_CMP_HI:  w_rdata_next = r_mtimecmp[63:32];
                REG_TIME_LO: w_rdata_next = r_mtime[31:0];
                REG_TIME_HI: w_rdata_next = r_mtime[63:32];
                default:     w_rdata_next = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mtime    <= 64'd0;
            r_mtimecmp <= '1;
            r_msip     <= 1'b0;
            r_mtip     <= 1'b0;
            r_ready    <= 1'b0;
            r_rdata    <= 32'd0;
        end else begin
            r_mtime    <= w_mtime_next;
            r_mtimecmp <= w_cmp_next;
            r_msip     <= w_msip_next;
            r_mtip     <= (r_mtime >= r_mtimecmp);
            r_ready    <= clint_valid;
            r_rdata    <= w_rdata_next;
        end
    end

    assign clint_rdata = r_rdata;
    assign clint_ready = r_ready;
    assign clint_msip  = r_msip;
    assign clint_mtip  = r_mtip;
    assign clint_mtime = r_mtime;

endmodule

// File: tb/tb_clint.sv
module tb_clint;
    import clint_pkg::*;

    localparam int TICK_PERIOD = 8;   // 2*(3+1) clocks

    logic        clock;
    logic        reset;
    logic        clint_valid;
    logic        clint_instr;
    logic [31:0] clint_addr;
    logic [31:0] clint_wdata;
    logic [3:0]  clint_wstrb;
    logic [31:0] clint_rdata;
    logic        clint_ready;
    logic        clint_msip;
    logic        clint_mtip;
    logic [63:0] clint_mtime;

    clint #(.clk_divider_rtc(16'd3)) dut (
        .clock       (clock),
        .reset       (reset),
        .clint_valid (clint_valid),
        .clint_instr (clint_instr),
        .clint_addr  (clint_addr),
        .clint_wdata (clint_wdata),
        .clint_wstrb (clint_wstrb),
        .clint_rdata (clint_rdata),
        .clint_ready (clint_ready),
        .clint_msip  (clint_msip),
        .clint_mtip  (clint_mtip),
        .clint_mtime (clint_mtime)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic        m_msip;
    int          edge_cnt;
    int          n_checks;
    int          n_fail;

    typedef struct {
        logic        instr;
        logic [15:0] off;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_msip;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] st);
        logic [31:0] x;
        x = old_v;
        for (int i = 0; i < 4; i++)
            if (st[i]) x[8*i +: 8] = new_v[8*i +: 8];
        return x;
    endfunction

    function automatic logic [15:0] word_off(input logic [31:0] a);
        logic [31:0] o;
        o = a - clint_base_addr;
        return o[15:0] & 16'hFFFC;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        case (word_off(a))
            16'h0000: return {31'd0, m_msip};
            16'h4000: return m_cmp[31:0];
            16'h4004: return m_cmp[63:32];
            16'hBFF8: return m_mtime[31:0];
            16'hBFFC: return m_mtime[63:32];
            default:  return 32'd0;
        endcase
    endfunction

    // One clock: drive request, advance the model, check every output.
    task automatic cycle(input logic v, input logic ins, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] st);
        logic [63:0] nt;
        logic [31:0] exp_rd;
        logic        exp_mtip;
        logic        is_wr;
        clint_valid = v;
        clint_instr = ins;
        clint_addr  = a;
        clint_wdata = wd;
        clint_wstrb = st;
        is_wr    = v && !ins && (st != 4'd0);
        exp_rd   = (v && !ins && st == 4'd0) ? model_read(a) : 32'd0;
        exp_mtip = (m_mtime >= m_cmp);
        nt = m_mtime + ((((edge_cnt + 1) % TICK_PERIOD) == 0) ? 64'd1 : 64'd0);
        if (is_wr) begin
            case (word_off(a))
                16'h0000: if (st[0]) m_msip = wd[0];
                16'h4000: m_cmp[31:0]  = merge(m_cmp[31:0], wd, st);
                16'h4004: m_cmp[63:32] = merge(m_cmp[63:32], wd, st);
                16'hBFF8: nt[31:0]     = merge(nt[31:0], wd, st);
                16'hBFFC: nt[63:32]    = merge(nt[63:32], wd, st);
                default: ;
            endcase
        end
        @(posedge clock);
        edge_cnt++;
        m_mtime = nt;
        @(negedge clock);
        check("ready", {63'd0, clint_ready}, {63'd0, v});
        if (!is_wr) check("rdata", {32'd0, clint_rdata}, {32'd0, exp_rd});
        check("msip", {63'd0, clint_msip}, {63'd0, m_msip});
        check("mtip", {63'd0, clint_mtip}, {63'd0, exp_mtip});
        check("mtime", clint_mtime, m_mtime);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic model_reset();
        m_mtime  = 64'd0;
        m_cmp    = '1;
        m_msip   = 1'b0;
        edge_cnt = 0;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        clint_valid = 1'b0;
        clint_instr = 1'b0;
        clint_addr  = 32'd0;
        clint_wdata = 32'd0;
        clint_wstrb = 4'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_ready", {63'd0, clint_ready}, 64'd0);
        check("rst_rdata", {32'd0, clint_rdata}, 64'd0);
        check("rst_msip",  {63'd0, clint_msip},  64'd0);
        check("rst_mtip",  {63'd0, clint_mtip},  64'd0);
        check("rst_mtime", clint_mtime, 64'd0);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [63:0] old_t;
        logic [63:0] exp_t;
        logic [31:0] ra;
        logic [3:0]  rs;
        int          n_ready;
        bit          found;
        logic [15:0] offs[8];

        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        model_reset();

        vecs[0]  = '{1'b0, 16'h0000, 32'h0000_0001, 4'b0001, 32'h0,         1'b1};
        vecs[1]  = '{1'b0, 16'h0000, 32'h0,         4'b0000, 32'h1,         1'b1};
        vecs[2]  = '{1'b0, 16'h0000, 32'hFFFF_FFFE, 4'b1111, 32'h0,         1'b0};
        vecs[3]  = '{1'b0, 16'h0000, 32'hFFFF_FFFF, 4'b0010, 32'h0,         1'b0};
        vecs[4]  = '{1'b0, 16'h0000, 32'h0,         4'b0000, 32'h0,         1'b0};
        vecs[5]  = '{1'b0, 16'h0000, 32'h0000_0003, 4'b0001, 32'h0,         1'b1};
        vecs[6]  = '{1'b0, 16'h0000, 32'h0,         4'b0000, 32'h1,         1'b1};
        vecs[7]  = '{1'b1, 16'h0000, 32'h0,         4'b0001, 32'h0,         1'b1};
        vecs[8]  = '{1'b0, 16'h1234, 32'h0,         4'b0000, 32'h0,         1'b1};
        vecs[9]  = '{1'b1, 16'hBFF8, 32'h0,         4'b0000, 32'h0,         1'b1};
        vecs[10] = '{1'b0, 16'h4000, 32'h1234_5678, 4'b1111, 32'h0,         1'b1};
        vecs[11] = '{1'b0, 16'h4000, 32'h0,         4'b0000, 32'h1234_5678, 1'b1};
        vecs[12] = '{1'b0, 16'h4004, 32'h0000_00AB, 4'b0001, 32'h0,         1'b1};
        vecs[13] = '{1'b0, 16'h4004, 32'h0,         4'b0000, 32'hFFFF_FFAB, 1'b1};
        vecs[14] = '{1'b0, 16'h4004, 32'hFFFF_FFFF, 4'b1111, 32'h0,         1'b1};
        vecs[15] = '{1'b0, 16'h0000, 32'h0,         4'b1111, 32'h0,         1'b0};
        vecs[16] = '{1'b0, 16'h4000, 32'h0,         4'b0000, 32'h1234_5678, 1'b0};
        vecs[17] = '{1'b0, 16'h1234, 32'hFFFF_FFFF, 4'b1111, 32'h0,         1'b0};
        vecs[18] = '{1'b0, 16'h0000, 32'h0,         4'b0000, 32'h0,         1'b0};

        offs[0] = 16'h0000; offs[1] = 16'h4000; offs[2] = 16'h4004; offs[3] = 16'hBFF8;
        offs[4] = 16'hBFFC; offs[5] = 16'h1234; offs[6] = 16'h0004; offs[7] = 16'h8000;

        // RTC tick timing out of reset
        do_reset();
        repeat (7) idle();
        check("mtime_pre_tick", clint_mtime, 64'd0);
        idle();
        check("mtime_first_tick", clint_mtime, 64'd1);
        repeat (24) idle();
        check("mtime_32clk", clint_mtime, 64'd4);

        // Register map vectors
        for (int i = 0; i < 19; i++) begin
            cycle(1'b1, vecs[i].instr, clint_base_addr + {16'd0, vecs[i].off},
                  vecs[i].wdata, vecs[i].wstrb);
            if (vecs[i].instr || vecs[i].wstrb == 4'd0)
                check($sformatf("vec%0d_rdata", i), {32'd0, clint_rdata}, {32'd0, vecs[i].exp_rdata});
            check($sformatf("vec%0d_msip", i), {63'd0, clint_msip}, {63'd0, vecs[i].exp_msip});
        end

        // Timer compare: mtip one cycle after mtime reaches 5
        do_reset();
        cycle(1'b1, 1'b0, clint_base_addr + 32'h4004, 32'h0, 4'b1111);
        cycle(1'b1, 1'b0, clint_base_addr + 32'h4000, 32'h5, 4'b1111);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            idle();
            if (clint_mtime == 64'd5) found = 1'b1;
        end
        check("mtime_reach5", {63'd0, found}, 64'd1);
        check("mtip_lag", {63'd0, clint_mtip}, 64'd0);
        idle();
        check("mtip_rise", {63'd0, clint_mtip}, 64'd1);
        cycle(1'b1, 1'b0, clint_base_addr + 32'h4004, 32'hFFFF_FFFF, 4'b1111);
        idle();
        check("mtip_drop", {63'd0, clint_mtip}, 64'd0);

        // 64-bit carry
        while ((edge_cnt % TICK_PERIOD) != 0) idle();
        cycle(1'b1, 1'b0, clint_base_addr + 32'hBFF8, 32'hFFFF_FFFF, 4'b1111);
        cycle(1'b1, 1'b0, clint_base_addr + 32'hBFFC, 32'h0, 4'b1111);
        while ((edge_cnt % TICK_PERIOD) != 0) idle();
        cycle(1'b1, 1'b0, clint_base_addr + 32'hBFF8, 32'h0, 4'b0000);
        check("carry_lo", {32'd0, clint_rdata}, 64'd0);
        cycle(1'b1, 1'b0, clint_base_addr + 32'hBFFC, 32'h0, 4'b0000);
        check("carry_hi", {32'd0, clint_rdata}, 64'd1);

        // Byte write to mtime on the tick cycle
        while (((edge_cnt + 1) % TICK_PERIOD) != 0) idle();
        old_t = m_mtime;
        cycle(1'b1, 1'b0, clint_base_addr + 32'hBFF8, 32'hA5A5_A5A5, 4'b0010);
        exp_t = old_t + 64'd1;
        exp_t[15:8] = 8'hA5;
        check("tick_write_mtime", clint_mtime, exp_t);

        // Back-to-back requests
        n_ready = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, clint_base_addr + {16'd0, offs[i]}, 32'h0, 4'b0000);
            if (clint_ready) n_ready++;
        end
        idle();
        check("b2b_ready_count", 64'(n_ready), 64'd4);
        check("b2b_ready_end", {63'd0, clint_ready}, 64'd0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            ra = clint_base_addr + {16'd0, offs[$urandom_range(0, 7)]} + 32'($urandom_range(0, 3));
            rs = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, ra, $urandom, rs);
        end

        // Reset in the cycle after a request
        cycle(1'b1, 1'b0, clint_base_addr, 32'h1, 4'b0001);
        clint_valid = 1'b1;
        clint_instr = 1'b0;
        clint_addr  = clint_base_addr;
        clint_wstrb = 4'd0;
        @(posedge clock);
        #1;
        reset       = 1'b1;
        clint_valid = 1'b0;
        @(negedge clock);
        check("midreq_ready", {63'd0, clint_ready}, 64'd0);
        check("midreq_rdata", {32'd0, clint_rdata}, 64'd0);
        check("midreq_msip",  {63'd0, clint_msip},  64'd0);
        check("midreq_mtime", clint_mtime, 64'd0);
        @(negedge clock);
        check("midreq_ready2", {63'd0, clint_ready}, 64'd0);
        reset = 1'b0;
        model_reset();
        cycle(1'b1, 1'b0, clint_base_addr + 32'h4000, 32'h0, 4'b0000);
        check("rst_cmp_lo", {32'd0, clint_rdata}, 64'hFFFF_FFFF);
        cycle(1'b1, 1'b0, clint_base_addr + 32'h4004, 32'h0, 4'b0000);
        check("rst_cmp_hi", {32'd0, clint_rdata}, 64'hFFFF_FFFF);
        repeat (3) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
